// File: rtl/overlay_mixer.sv
// Overlay mixer: tracks active-area x/y, pops overlay pixels inside a fixed
// window, keys out transparent pixels and re-times sync/DE with the data.
module overlay_mixer #(
   parameter int          hCountWidth = 12,
   parameter int          vCountWidth = 12,
   parameter int          overlayX    = 100,
   parameter int          overlayY    = 100,
   parameter int          overlayW    = 320,
   parameter int          overlayH    = 240,
   parameter logic [23:0] keyColour   = 24'hFF00FF
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        deIn,
   input  logic        hSyncIn,
   input  logic        vSyncIn,
   input  logic [23:0] backgroundData,
   input  logic        overlayEnable,
   input  logic [23:0] pixelData,
   input  logic        pixelValid,
   output logic        pixelReady,
   output logic        frameStart,
   output logic        underflow,
   output logic        DE,
   output logic        HSYNC,
   output logic        VSYNC,
   output logic [23:0] data
);

   localparam int HW = hCountWidth + 1;
   localparam int VW = vCountWidth + 1;

   // one extra bit so x+W / y+H bounds cannot wrap
   localparam logic [HW-1:0] x_lo = HW'(overlayX);
   localparam logic [HW-1:0] x_hi = HW'(overlayX + overlayW);
   localparam logic [VW-1:0] y_lo = VW'(overlayY);
   localparam logic [VW-1:0] y_hi = VW'(overlayY + overlayH);

   logic [hCountWidth-1:0] x;
   logic [vCountWidth-1:0] y;
   logic [HW-1:0]          x_ext;
   logic [VW-1:0]          y_ext;
   logic                   in_window;
   logic                   vs_rise;
   logic                   de_fall;
   logic                   starve;
   logic [23:0]            pix_sel;

   assign x_ext = {1'b0, x};
   assign y_ext = {1'b0, y};

   assign in_window = (x_ext >= x_lo) && (x_ext < x_hi) &&
                      (y_ext >= y_lo) && (y_ext < y_hi);

   assign pixelReady = reset_n & deIn & in_window & overlayEnable;

   // DE/VSYNC registers double as the edge-detect history
   assign vs_rise = vSyncIn & ~VSYNC;
   assign de_fall = DE & ~deIn;
   assign starve  = pixelReady & ~pixelValid;

   always_comb begin
      pix_sel = backgroundData;
      if (!deIn)
         pix_sel = 24'h0;
      else if (pixelReady && pixelValid && pixelData != keyColour)
         pix_sel = pixelData;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         x <= '0;
      end else if (!deIn) begin
         x <= '0;
      end else if (!(&x)) begin
         x <= x + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         y <= '0;
      end else if (vs_rise) begin
         y <= '0;
      end else if (de_fall && !(&y)) begin
         y <= y + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         DE         <= 1'b0;
         HSYNC      <= 1'b0;
         VSYNC      <= 1'b0;
         data       <= 24'h0;
         frameStart <= 1'b0;
      end else begin
         DE         <= deIn;
         HSYNC      <= hSyncIn;
         VSYNC      <= vSyncIn;
         data       <= pix_sel;
         frameStart <= vs_rise;
      end
   end

   // set beats the frame-start clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         underflow <= 1'b0;
      end else if (starve) begin
         underflow <= 1'b1;
      end else if (vs_rise) begin
         underflow <= 1'b0;
      end
   end

endmodule

// File: doc/overlay_mixer.md
# overlay_mixer

Pixel-path stage between the video timing generator (hsync/vsync/DE) and the HDMI transmitter data bus. It tracks the active-area column and row from DE and VSYNC and pops overlay pixels from an upstream DDR-fed pixel FIFO inside a fixed rectangular window. Key-coloured overlay pixels are transparent; every other overlay pixel replaces the background. Timing signals are re-registered with the same 1-cycle latency as the data, so DE, HSYNC, VSYNC and RGB stay aligned at the pins.

## Interface
- hCountWidth, 12, width of column counter
- vCountWidth, 12, width of row counter
- overlayX, 100, first overlay column (0-based, active-area coordinates)
- overlayY, 100, first overlay row
- overlayW, 320, overlay width in pixels (≥1)
- overlayH, 240, overlay height in rows (≥1)
- keyColour, 24'hFF00FF, transparent RGB value
---
- clock  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- deIn  in  1  data enable from timing generator
- hSyncIn  in  1  horizontal sync (active high)
- vSyncIn  in  1  vertical sync (active high)
- backgroundData  in  24  background RGB
- overlayEnable  in  1  level; 0 = pass background, no FIFO pops
- pixelData  in  24  overlay RGB from FIFO head
- pixelValid  in  1  FIFO head valid
- pixelReady  out  1  pop strobe; pop occurs when pixelReady & pixelValid
- frameStart  out  1  1-cycle pulse telling the DDR reader to restart at image address 0
- underflow  out  1  sticky: a window pixel was needed while pixelValid=0
- DE, HSYNC, VSYNC  out  1 each  registered timing
- data  out  24  registered RGB

## Operation
- Column counter x: resets to 0 whenever deIn=0. Increments on each deIn=1 cycle and saturates at all-ones. During a deIn=1 cycle, the current pixel column is x.
- Row counter y: increments on the DE falling edge (deIn registered high, deIn now low). Clears to 0 on the vSyncIn rising edge. If both events occur in the same cycle, the clear wins (y=0). y saturates at all-ones.
- inWindow = (overlayX ≤ x < overlayX+overlayW) & (overlayY ≤ y < overlayY+overlayH). Compare at hCountWidth+1 / vCountWidth+1 bits so the sums cannot wrap.
- pixelReady = deIn & inWindow & overlayEnable. This is combinational and is not gated by pixelValid.
- Pixel select per deIn=1 cycle:
  - pixelReady & pixelValid & pixelData≠keyColour → pixelData
  - pixelReady & pixelValid & pixelData==keyColour → backgroundData (the pixel is still consumed)
  - pixelReady & !pixelValid → backgroundData, and underflow sets
  - otherwise → backgroundData
- When deIn=0, the selected data is 24'h0.
- frameStart: registered pulse in the cycle after the vSyncIn rising edge is detected.
- underflow clears in the same cycle that frameStart asserts. If a set and a clear coincide, set wins. A set cannot occur during VSYNC if the timing generator keeps DE low there.
- Dropped pixels are not re-fetched. Image realignment relies only on frameStart.
- overlayEnable may change at any cycle and takes effect on the next pixel.

## Timing
- Reset (reset_n=0, asynchronous) clears: x, y, edge-detect registers, DE, HSYNC, VSYNC, data, frameStart, underflow.
- pixelReady reads 0 during reset because x/y are 0 and the output is gated with reset_n.
- First edge after release: vSyncIn/deIn edge detectors start from 0. A vSyncIn already high at release counts as a rising edge.
- Latency: DE, HSYNC, VSYNC and data equal the clock-N inputs at clock N+1.
- pixelReady is combinational in the same cycle as deIn. The FIFO pops on the clock edge that ends that cycle.
- frameStart is 1 cycle wide and occurs 1 cycle after the vSyncIn rise.
- Sustained throughput: one pop per clock across a window row.

## Test plan
- Params X=2, Y=1, W=3, H=2, 8-pixel lines, FIFO always valid with values 1,2,3,…; background 24'hAAAAAA. Expect on row 0: 8×AAAAAA. Row 1, columns 2–4: 1,2,3, other columns AAAAAA. Row 2: 4,5,6. Row 3: all AAAAAA. Exactly 6 pops.
- Same setup, 3rd FIFO entry = keyColour. Expect row 1 column 4 = AAAAAA and the pop count still 6.
- pixelValid=0 for the first window pixel. Expect data=AAAAAA at that slot and underflow=1, held until the next frameStart, then 0.
- vSyncIn rises in the same cycle as the DE falling edge. Expect y=0, frameStart pulse 1 cycle later, and the next line treated as row 0.
- overlayEnable=0 for a whole frame. Expect pixelReady never asserts and data equals the delayed background.
- Assert reset_n=0 mid-line while deIn=1. Expect all outputs 0 immediately (asynchronous). After release, the line restarts at x=0 and DE/HSYNC/VSYNC are 1-cycle delayed copies of the inputs.
